// File: rtl/flash_if_pkg.sv
// Shared definitions for the flash read interface, used by the player-side
// reader and by flash_read_responder.
//   FLASH_ADDR_W / FLASH_DATA_W / FLASH_BE_W : default bus widths
//   flash_req_t : request captured on accept (word address + byte lanes)
//   flash_rsp_t : response beat (data + valid qualifier)
package flash_if_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int FLASH_BE_W   = 4;

  typedef struct packed {
    logic [FLASH_ADDR_W-1:0] addr;
    logic [FLASH_BE_W-1:0]   be;
  } flash_req_t;

  typedef struct packed {
    logic [FLASH_DATA_W-1:0] data;
    logic                    valid;
  } flash_rsp_t;

endpackage

// File: rtl/flash_read_responder_if.sv
// Avalon-MM read-only flash bus between the audio player (master) and the
// flash responder (slave).
//   flsh_address       master -> slave  word address
//   flsh_read          master -> slave  read request
//   flsh_byteenable    master -> slave  byte lanes to return
//   flsh_waitrequest   slave -> master  stall
//   flsh_readdata      slave -> master  returned data
//   flsh_readdatavalid slave -> master  one-cycle qualifier for readdata
interface flash_read_responder_if
  import flash_if_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W
) ();

  logic [ADDR_W-1:0]   flsh_address;
  logic                flsh_read;
  logic [DATA_W/8-1:0] flsh_byteenable;
  logic                flsh_waitrequest;
  logic [DATA_W-1:0]   flsh_readdata;
  logic                flsh_readdatavalid;

  modport master (
    output flsh_address, flsh_read, flsh_byteenable,
    input  flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );

  modport slave (
    input  flsh_address, flsh_read, flsh_byteenable,
    output flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );

endinterface

// File: rtl/read_return_pipe.sv
// Fixed-latency return pipeline: a word pushed in on one edge appears at the
// output exactly READ_LATENCY edges later, qualified by a one-cycle ret pulse.
//   clk, rst  : clock, synchronous active-high clear of all stages
//   in_valid  : push a word this cycle
//   in_data   : word to push
//   ret       : output qualifier (last stage valid)
//   data      : output word; holds its last value while ret=0
module read_return_pipe #(
  parameter int READ_LATENCY = 3,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              ret,
  output logic [DATA_W-1:0] data
);

  logic [READ_LATENCY-1:0] vld_r;
  logic [DATA_W-1:0]       dat_r [READ_LATENCY];

  // Shift valid bits every cycle; a data stage only loads when a valid word
  // moves into it, so the last stage keeps the previous return while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= in_valid;
      if (in_valid) begin
        dat_r[0] <= in_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign ret  = vld_r[READ_LATENCY-1];
  assign data = dat_r[READ_LATENCY-1];

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read slave standing in for the flash controller. Requests are
// served from an on-chip word array after WAIT_STATES stall cycles, and data
// returns READ_LATENCY cycles after accept, with at most MAX_PENDING reads
// in flight.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : flash read bus (slave side)
//   ld_write     : write ld_writedata into mem[ld_address] (also during rst)
//   ld_address   : load word index
//   ld_writedata : load data
//   pending      : reads accepted and not yet returned
module flash_read_responder
  import flash_if_pkg::*;
#(
  parameter int ADDR_W       = FLASH_ADDR_W,
  parameter int DATA_W       = FLASH_DATA_W,
  parameter int MEM_WORDS    = 1024,
  parameter int WAIT_STATES  = 2,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  flash_read_responder_if.slave            bus,
  input  logic                             ld_write,
  input  logic [$clog2(MEM_WORDS)-1:0]     ld_address,
  input  logic [DATA_W-1:0]                ld_writedata,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BE_W   = DATA_W / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic [DATA_W-1:0] mem_r [MEM_WORDS];
  logic [WCNT_W-1:0] wcnt_r;
  logic [PEND_W-1:0] pending_r;
  logic              ws_stall_s;
  logic              full_s;
  logic              wait_s;
  logic              accept_s;
  logic              ret_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] masked_s;
  logic [DATA_W-1:0] rdata_s;
  logic              unused_addr_s;

  // Zero every byte lane whose enable is low.
  function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] word,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = word[8*b +: 8];
      end else begin
        res[8*b +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  // Wait-state stall; with no wait states the counter is never consulted.
  if (WAIT_STATES == 0) begin : g_no_ws
    logic unused_wcnt_s;
    assign unused_wcnt_s = ^wcnt_r;
    assign ws_stall_s    = 1'b0;
  end else begin : g_ws
    assign ws_stall_s = (wcnt_r < WCNT_W'(WAIT_STATES));
  end

  // A slot freed by this cycle's return may be reused immediately.
  assign full_s   = (pending_r == PEND_MAX) && !ret_s;
  assign wait_s   = bus.flsh_read && (ws_stall_s || full_s);
  assign accept_s = bus.flsh_read && !wait_s;

  // Upper address bits alias onto the array.
  assign idx_s         = bus.flsh_address[IDX_W-1:0];
  assign unused_addr_s = ^bus.flsh_address[ADDR_W-1:IDX_W];
  assign masked_s      = mask_lanes(mem_r[idx_s], bus.flsh_byteenable);

  // Wait counter: counts stalled cycles of a held read, forgets abandoned ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r <= '0;
    end else if (!bus.flsh_read || accept_s) begin
      wcnt_r <= '0;
    end else if (ws_stall_s) begin
      wcnt_r <= wcnt_r + WCNT_W'(1);
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // Outstanding-read counter: +1 on accept, -1 on return.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      case ({accept_s, ret_s})
        2'b10:   pending_r <= pending_r + PEND_W'(1);
        2'b01:   pending_r <= pending_r - PEND_W'(1);
        default: pending_r <= pending_r;
      endcase
    end
  end

  // Backing array; loads are never blocked, and an accept reading the same
  // word in the same cycle sees the pre-load contents.
  always_ff @(posedge clk) begin
    if (ld_write) begin
      mem_r[ld_address] <= ld_writedata;
    end
  end

  read_return_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_W       (DATA_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept_s),
    .in_data  (masked_s),
    .ret      (ret_s),
    .data     (rdata_s)
  );

  assign bus.flsh_waitrequest   = wait_s;
  assign bus.flsh_readdatavalid = ret_s;
  assign bus.flsh_readdata      = rdata_s;
  assign pending                = pending_r;

endmodule

// File: tb/tb_flash_read_responder.sv
module tb_flash_read_responder;
  import flash_if_pkg::*;

  localparam int WS_A = 2, L_A = 3, MP_A = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  flash_read_responder_if #(.ADDR_W(23), .DATA_W(32)) a_if ();
  flash_read_responder_if #(.ADDR_W(23), .DATA_W(32)) b_if ();
  logic        a_ld_write, b_ld_write;
  logic [9:0]  a_ld_address, b_ld_address;
  logic [31:0] a_ld_writedata, b_ld_writedata;
  logic [2:0]  a_pending;
  logic [1:0]  b_pending;

  flash_read_responder #(.ADDR_W(23), .DATA_W(32), .MEM_WORDS(1024), .WAIT_STATES(WS_A),
                         .READ_LATENCY(L_A), .MAX_PENDING(MP_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .ld_write(a_ld_write), .ld_address(a_ld_address),
    .ld_writedata(a_ld_writedata), .pending(a_pending));

  flash_read_responder #(.ADDR_W(23), .DATA_W(32), .MEM_WORDS(1024), .WAIT_STATES(0),
                         .READ_LATENCY(3), .MAX_PENDING(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .ld_write(b_ld_write), .ld_address(b_ld_address),
    .ld_writedata(b_ld_writedata), .pending(b_pending));

  int checks = 0, errors = 0;

  // Reference model of DUT A: array contents, queue of scheduled returns.
  typedef struct { int due; logic [31:0] data; } ret_t;
  ret_t        q[$];
  logic [31:0] mem_m [1024];
  int          waited = 0;
  int          cyc = 0;
  int          last_cyc;
  bit          last_acc, last_wr;
  flash_rsp_t  last_rsp;

  // Expected-value record for the DUT B throttle table.
  typedef struct {
    logic        read;
    logic [22:0] addr;
    logic        exp_wr;
    logic        exp_valid;
    logic [31:0] exp_data;
    int          exp_pend;
  } brow_t;
  brow_t b_exp;
  bit    b_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask_m(input logic [31:0] w, input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = w[8*b +: 8];
    return m;
  endfunction

  // One clock cycle: compare at negedge against the model, advance the model.
  task automatic step();
    bit ret_e, full_e, wr_e, acc_e;
    @(negedge clk);
    ret_e  = (q.size() > 0) && (q[0].due == cyc);
    full_e = (q.size() == MP_A) && !ret_e;
    wr_e   = a_if.flsh_read && ((waited < WS_A) || full_e);
    acc_e  = a_if.flsh_read && !wr_e;
    last_rsp.valid = a_if.flsh_readdatavalid;
    last_rsp.data  = a_if.flsh_readdata;
    if (!rst) begin
      chk("a_waitrequest", a_if.flsh_waitrequest, wr_e);
      chk("a_readdatavalid", a_if.flsh_readdatavalid, ret_e);
      chk("a_pending", 32'(a_pending), 32'(q.size()));
      if (ret_e) chk("a_readdata", a_if.flsh_readdata, q[0].data);
      if (b_on) begin
        chk("b_waitrequest", b_if.flsh_waitrequest, b_exp.exp_wr);
        chk("b_readdatavalid", b_if.flsh_readdatavalid, b_exp.exp_valid);
        chk("b_pending", 32'(b_pending), 32'(b_exp.exp_pend));
        if (b_exp.exp_valid) chk("b_readdata", b_if.flsh_readdata, b_exp.exp_data);
      end
    end
    if (rst) begin
      q.delete();
      waited = 0;
      acc_e  = 1'b0;
    end else begin
      if (ret_e) void'(q.pop_front());
      if (acc_e) q.push_back('{cyc + L_A,
                               mask_m(mem_m[a_if.flsh_address[9:0]], a_if.flsh_byteenable)});
      waited = (a_if.flsh_read && !acc_e) ? ((waited < WS_A) ? waited + 1 : WS_A) : 0;
    end
    if (a_ld_write) mem_m[a_ld_address] = a_ld_writedata;
    last_acc = acc_e;
    last_wr  = wr_e;
    last_cyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [9:0] idx, input logic [31:0] d);
    a_ld_write = 1'b1; a_ld_address = idx; a_ld_writedata = d;
    step();
    a_ld_write = 1'b0;
  endtask

  // Hold a read until accepted, then wait for its return (both bounded).
  task automatic read_one(input logic [22:0] addr, input logic [3:0] be,
                          output logic [31:0] data, output int acc_d, output int ret_d);
    int start, acc_c, ret_c;
    start = cyc; acc_c = -1; ret_c = -1; data = '0;
    a_if.flsh_read = 1'b1; a_if.flsh_address = addr; a_if.flsh_byteenable = be;
    for (int k = 0; k < 20 && acc_c < 0; k++) begin
      step();
      if (last_acc) acc_c = last_cyc;
    end
    a_if.flsh_read = 1'b0;
    for (int k = 0; k < 20 && ret_c < 0; k++) begin
      step();
      if (last_rsp.valid) begin ret_c = last_cyc; data = last_rsp.data; end
    end
    if (acc_c < 0 || ret_c < 0) begin
      checks++; errors++;
      $display("FAIL read_one_timeout addr=%h accepted=%0d returned=%0d", addr, acc_c, ret_c);
    end
    acc_d = acc_c - start;
    ret_d = ret_c - acc_c;
  endtask

  typedef struct { logic [9:0] idx; logic [31:0] word; logic [3:0] be; logic [31:0] exp; } mrow_t;

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mrow_t       mtbl[4];
    brow_t       btbl[8];
    logic [31:0] d;
    int          ad, rd, nval;

    mtbl[0] = '{10'd7,  32'h12345678, 4'b0011, 32'h00005678};
    mtbl[1] = '{10'd7,  32'h12345678, 4'b1100, 32'h12340000};
    mtbl[2] = '{10'd3,  32'hCAFEF00D, 4'b0000, 32'h00000000};
    mtbl[3] = '{10'd12, 32'hA5A5A5A5, 4'b1001, 32'hA50000A5};

    // read, addr, waitrequest, valid, data, pending  (WS=0, MP=2, L=3)
    btbl[0] = '{1'b1, 23'd0, 1'b0, 1'b0, 32'h0, 0};
    btbl[1] = '{1'b1, 23'd1, 1'b0, 1'b0, 32'h0, 1};
    btbl[2] = '{1'b1, 23'd2, 1'b1, 1'b0, 32'h0, 2};
    btbl[3] = '{1'b1, 23'd2, 1'b0, 1'b1, 32'hB0000000, 2};
    btbl[4] = '{1'b0, 23'd0, 1'b0, 1'b1, 32'hB0000001, 2};
    btbl[5] = '{1'b0, 23'd0, 1'b0, 1'b0, 32'h0, 1};
    btbl[6] = '{1'b0, 23'd0, 1'b0, 1'b1, 32'hB0000002, 1};
    btbl[7] = '{1'b0, 23'd0, 1'b0, 1'b0, 32'h0, 0};

    rst = 1'b1;
    a_if.flsh_read = 1'b0; a_if.flsh_address = '0; a_if.flsh_byteenable = 4'hF;
    b_if.flsh_read = 1'b0; b_if.flsh_address = '0; b_if.flsh_byteenable = 4'hF;
    a_ld_write = 1'b0; a_ld_address = '0; a_ld_writedata = '0;
    b_ld_write = 1'b0; b_ld_address = '0; b_ld_writedata = '0;

    // Preload both arrays while reset is held (loads work during reset).
    for (int i = 0; i < 16; i++) begin
      a_ld_write = 1'b1; a_ld_address = 10'(i); a_ld_writedata = $urandom;
      b_ld_write = 1'b1; b_ld_address = 10'(i); b_ld_writedata = 32'hB0000000 + 32'(i);
      step();
    end
    a_ld_write = 1'b0; b_ld_write = 1'b0;
    rst = 1'b0;

    chk("rst_a_readdata", a_if.flsh_readdata, 32'h0);
    chk("rst_a_valid", a_if.flsh_readdatavalid, 1'b0);
    chk("rst_a_pending", 32'(a_pending), 32'd0);
    chk("rst_a_waitrequest", a_if.flsh_waitrequest, 1'b0);
    chk("rst_b_readdata", b_if.flsh_readdata, 32'h0);
    chk("rst_b_pending", 32'(b_pending), 32'd0);

    // Basic timing.
    load_a(10'd5, 32'hDEADBEEF);
    read_one(23'd5, 4'hF, d, ad, rd);
    chk("basic_accept_delay", 32'(ad), 32'd2);
    chk("basic_return_delay", 32'(rd), 32'd3);
    chk("basic_data", d, 32'hDEADBEEF);

    // Byte masking table.
    foreach (mtbl[i]) begin
      load_a(mtbl[i].idx, mtbl[i].word);
      read_one({13'd0, mtbl[i].idx}, mtbl[i].be, d, ad, rd);
      chk("mask_data", d, mtbl[i].exp);
      chk("mask_return_delay", 32'(rd), 32'd3);
    end

    // Throttle on DUT B.
    foreach (btbl[i]) begin
      b_if.flsh_read = btbl[i].read; b_if.flsh_address = btbl[i].addr;
      b_exp = btbl[i]; b_on = 1'b1;
      step();
    end
    b_on = 1'b0; b_if.flsh_read = 1'b0;

    // Abandon: one cycle of read, then nothing.
    a_if.flsh_read = 1'b1; a_if.flsh_address = 23'd3;
    step();
    chk("abandon_no_accept", last_acc, 1'b0);
    a_if.flsh_read = 1'b0;
    nval = 0;
    for (int k = 0; k < 10; k++) begin step(); if (last_rsp.valid) nval++; end
    chk("abandon_no_valid", 32'(nval), 32'd0);
    chk("abandon_pending", 32'(a_pending), 32'd0);
    read_one(23'd5, 4'hF, d, ad, rd);
    chk("abandon_rewait", 32'(ad), 32'd2);

    // Reset mid-flight.
    a_if.flsh_read = 1'b1; a_if.flsh_address = 23'd5; a_if.flsh_byteenable = 4'hF;
    ad = 0;
    for (int k = 0; k < 10 && !last_acc; k++) step();
    chk("midrst_accepted", last_acc, 1'b1);
    a_if.flsh_read = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pending", 32'(a_pending), 32'd0);
    nval = 0;
    for (int k = 0; k < 8; k++) begin step(); if (last_rsp.valid) nval++; end
    chk("midrst_no_valid", 32'(nval), 32'd0);
    read_one(23'd5, 4'hF, d, ad, rd);
    chk("midrst_accept_delay", 32'(ad), 32'd2);
    chk("midrst_return_delay", 32'(rd), 32'd3);
    chk("midrst_data", d, 32'hDEADBEEF);

    // Address wrap.
    load_a(10'd0, 32'h0BADF00D);
    read_one(23'h000400, 4'hF, d, ad, rd);
    chk("wrap_data", d, 32'h0BADF00D);

    // Load colliding with an accept of the same word.
    load_a(10'd9, 32'h11111111);
    a_if.flsh_read = 1'b1; a_if.flsh_address = 23'd9; a_if.flsh_byteenable = 4'hF;
    step();
    step();
    a_ld_write = 1'b1; a_ld_address = 10'd9; a_ld_writedata = 32'hAAAA5555;
    step();
    chk("collide_accept", last_acc, 1'b1);
    a_ld_write = 1'b0; a_if.flsh_read = 1'b0;
    d = '0; nval = 0;
    for (int k = 0; k < 10 && nval == 0; k++) begin
      step();
      if (last_rsp.valid) begin nval = 1; d = last_rsp.data; end
    end
    chk("collide_old_data", d, 32'h11111111);
    read_one(23'd9, 4'hF, d, ad, rd);
    chk("collide_new_data", d, 32'hAAAA5555);

    // Randomised traffic against the model; stalled requests are held.
    for (int n = 0; n < 800; n++) begin
      if (!(a_if.flsh_read && last_wr && $urandom_range(0, 9) != 0)) begin
        a_if.flsh_read       = ($urandom_range(0, 9) < 6);
        a_if.flsh_address    = {13'($urandom), 6'b0, 4'($urandom)};
        a_if.flsh_byteenable = 4'($urandom);
      end
      a_ld_write     = ($urandom_range(0, 4) == 0);
      a_ld_address   = 10'($urandom_range(0, 15));
      a_ld_writedata = $urandom;
      rst            = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; a_if.flsh_read = 1'b0; a_ld_write = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("final_pending", 32'(a_pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Synthesizable Avalon-MM read slave. It is the responder end of the flash read interface that our audio player drives: address, read, waitrequest, readdata, readdatavalid, byteenable.
- Backs requests with an on-chip word array. This stands in for the flash controller in simulation and on boards without flash.
- Inserts configurable wait states and a configurable pipelined read latency.
- A load port lets the bench or a host preload sample data.

Parameters:
- ADDR_W, 23, width of flsh_address (word address).
- DATA_W, 32, width of readdata, writedata and array words.
- MEM_WORDS, 1024, depth of the backing array (power of 2). Index = flsh_address[$clog2(MEM_WORDS)-1:0].
- WAIT_STATES, 2, waitrequest cycles before a held read is accepted (0 allowed).
- READ_LATENCY, 3, cycles from accept to readdatavalid (>=1).
- MAX_PENDING, 4, maximum reads accepted and not yet returned (1..READ_LATENCY).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flsh_address  in  ADDR_W  read word address.
- flsh_read  in  1  read request.
- flsh_byteenable  in  DATA_W/8  byte lanes to return.
- flsh_waitrequest  out  1  stall; the request is accepted on a cycle with read=1 and waitrequest=0.
- flsh_readdata  out  DATA_W  returned data.
- flsh_readdatavalid  out  1  one-cycle qualifier for readdata.
- ld_write  in  1  write one word into the array.
- ld_address  in  $clog2(MEM_WORDS)  load word index.
- ld_writedata  in  DATA_W  load data.
- pending  out  $clog2(MAX_PENDING+1)  count of outstanding reads.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wait counter wcnt=0, all pipeline valid bits=0, readdatavalid=0, readdata=0, pending=0.
  - Array contents are not reset.
  - Reset mid-operation drops all in-flight reads; no readdatavalid ever appears for them.
- Wait-state counter:
  - wcnt increments on each cycle with flsh_read=1 and no accept, saturating at WAIT_STATES.
  - wcnt clears on accept, and on any cycle with flsh_read=0 (an abandoned request is forgotten).
- Waitrequest is combinational: flsh_waitrequest = flsh_read && (wcnt < WAIT_STATES || full).
  - full = (pending == MAX_PENDING) && !ret, where ret is the current-cycle readdatavalid.
  - A slot freed by a return can be refilled in the same cycle.
  - waitrequest is 0 whenever flsh_read=0.
- Accept = flsh_read && !flsh_waitrequest.
  - Address and byteenable are sampled only on the accept cycle. Values while stalled are ignored.
  - The master must hold them; the responder does not check this.
- Read path:
  - On accept, word mem[index] is masked per lane: disabled bytes become 0x00.
  - The masked word enters a READ_LATENCY-deep shift pipeline with a valid bit.
  - flsh_readdatavalid=1 and flsh_readdata=data exactly READ_LATENCY cycles after the accept edge.
  - Returns are in order.
  - readdata holds its last value when valid=0. Checkers must only sample with valid=1.
- Address wrap: upper address bits above the index are ignored, so addresses alias modulo MEM_WORDS.
- pending: +1 on accept, -1 on return; both in the same cycle leave it unchanged. It never exceeds MAX_PENDING.
- Load port:
  - ld_write writes mem[ld_address] at the edge.
  - If a load and an accept hit the same word in the same cycle, the read returns the old data (read-before-write).
  - Loads are always accepted, including during rst.
- No write path on the flash side. flsh_byteenable=0 returns 0x00000000 with a normal valid pulse.

Decomposition:
- Package flash_if_pkg:
  - constants FLASH_ADDR_W=23, FLASH_DATA_W=32, FLASH_BE_W=4.
  - typedef flash_req_t {addr, be}.
  - typedef flash_rsp_t {data, valid}.
  - shared by the player-side reader and this responder.
- Sub-module read_return_pipe:
  - parameterized by READ_LATENCY and DATA_W.
  - shift register with valid bits, synchronous clear on rst.
  - outputs ret/data.

Test Plan:
- Basic timing (WAIT_STATES=2, READ_LATENCY=3):
  - Stimulus: load mem[5]=0xDEADBEEF; hold read=1, addr=5, be=0xF from cycle 0.
  - Response: waitrequest=1 in cycles 0–1, =0 in cycle 2 (accept); readdatavalid only in cycle 5 with 0xDEADBEEF; pending 1 during cycles 3–5, 0 after.
- Byte masking:
  - Stimulus: mem[7]=0x12345678, read with be=4'b0011, then be=4'b1100.
  - Response: returns 0x00005678, then 0x12340000.
- Throttle (WAIT_STATES=0, MAX_PENDING=2, READ_LATENCY=3):
  - Stimulus: read held for addresses 0, 1, 2.
  - Response: accepts in cycles 0 and 1; waitrequest=1 in cycle 2; accept in cycle 3 alongside the first return; returns in cycles 3, 4, 6; pending never exceeds 2.
- Abandon:
  - Stimulus: WAIT_STATES=2, read=1 for one cycle then 0.
  - Response: no accept, no readdatavalid for 10 cycles, pending=0; a later held read again sees 2 wait cycles.
- Reset mid-flight:
  - Stimulus: accept a read, assert rst one cycle later.
  - Response: readdatavalid stays 0; pending=0 after reset; the next read behaves as in the basic-timing scenario.
- Wrap and load collision:
  - Stimulus: read address 0x000400 with MEM_WORDS=1024.
  - Response: returns mem[0].
  - Stimulus: load mem[9]=0xAAAA5555 in the same cycle as an accept of address 9 holding 0x11111111.
  - Response: first read returns 0x11111111; a subsequent read returns 0xAAAA5555.
